// File: rtl/dump_pkg.sv
// rtl/dump_pkg.sv - shared constants, tag helper and FSM state type for debug_dump
// Port summary: none (package).
package dump_pkg;

  localparam int NREG = 32;
  localparam int NMEM = 8;

  // Tag kind field, placed in out_tag_o[7:6].
  localparam logic [1:0] KIND_HDR = 2'b00;
  localparam logic [1:0] KIND_REG = 2'b01;
  localparam logic [1:0] KIND_MEM = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FREEZE,
    ST_HDR,
    ST_REG,
    ST_MEM,
    ST_DONE
  } dump_state_e;

  function automatic logic [7:0] make_tag(input logic [1:0] kind, input logic [5:0] idx);
    return {kind, idx};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up counter with async clear and synchronous load
// Ports: clk_i clock; rst_i async active-high clear; en_i count enable;
//        load_i/load_val_i synchronous preload (wins over en_i); count_o current value.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/debug_dump.sv
// rtl/debug_dump.sv - freezes the CPU and streams cycle count, register file and data memory
// Ports: clk_i/rst_i clock and async active-high reset; start_i CPU running qualifier;
//        trigger_i dump request; reg_addr_o/reg_data_i and mem_addr_o/mem_data_i combinational
//        read ports; cpu_stall_o CPU freeze; out_valid_o/out_ready_i/out_data_o/out_tag_o/
//        out_last_o beat stream; busy_o dump in progress; cycle_o running cycle count.
module debug_dump
  import dump_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        trigger_i,
  output logic [4:0]  reg_addr_o,
  input  logic [31:0] reg_data_i,
  output logic [2:0]  mem_addr_o,
  input  logic [31:0] mem_data_i,
  output logic        cpu_stall_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic [7:0]  out_tag_o,
  output logic        out_last_o,
  output logic        busy_o,
  output logic [31:0] cycle_o
);

  dump_state_e state_q;
  logic        stall_q;
  logic        busy_q;
  logic        valid_q;
  logic        last_q;
  logic [31:0] data_q;
  logic [7:0]  tag_q;
  logic [4:0]  reg_addr_q;
  logic [2:0]  mem_addr_q;
  logic [31:0] cycle_w;
  logic        xfer;

  sat_counter #(.WIDTH(32)) u_cycle_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (start_i && !stall_q),
    .load_i     (1'b0),
    .load_val_i (32'd0),
    .count_o    (cycle_w)
  );

  assign xfer = valid_q && out_ready_i;

  // The address registers always point at the beat that will be loaded on the next
  // handshake, so the read ports settle a full cycle before their data is captured.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      stall_q    <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= '0;
      tag_q      <= '0;
      reg_addr_q <= '0;
      mem_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trigger_i) begin
            state_q <= ST_FREEZE;
            stall_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_FREEZE: begin
          state_q <= ST_HDR;
        end
        ST_HDR: begin
          if (!valid_q) begin
            // Counter is stalled since FREEZE entry, so this is the frozen value.
            valid_q <= 1'b1;
            data_q  <= cycle_w;
            tag_q   <= make_tag(KIND_HDR, 6'd0);
          end else if (xfer) begin
            data_q     <= reg_data_i;
            tag_q      <= make_tag(KIND_REG, {1'b0, reg_addr_q});
            reg_addr_q <= reg_addr_q + 5'd1;
            state_q    <= ST_REG;
          end
        end
        ST_REG: begin
          if (xfer) begin
            if (tag_q[5:0] == 6'(NREG - 1)) begin
              data_q     <= mem_data_i;
              tag_q      <= make_tag(KIND_MEM, {3'b000, mem_addr_q});
              mem_addr_q <= mem_addr_q + 3'd1;
              state_q    <= ST_MEM;
            end else begin
              data_q     <= reg_data_i;
              tag_q      <= make_tag(KIND_REG, {1'b0, reg_addr_q});
              reg_addr_q <= reg_addr_q + 5'd1;
            end
          end
        end
        ST_MEM: begin
          if (xfer) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state_q <= ST_DONE;
            end else begin
              data_q     <= mem_data_i;
              tag_q      <= make_tag(KIND_MEM, {3'b000, mem_addr_q});
              mem_addr_q <= mem_addr_q + 3'd1;
              last_q     <= (mem_addr_q == 3'(NMEM - 1));
            end
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          stall_q    <= 1'b0;
          busy_q     <= 1'b0;
          reg_addr_q <= '0;
          mem_addr_q <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign reg_addr_o  = reg_addr_q;
  assign mem_addr_o  = mem_addr_q;
  assign cpu_stall_o = stall_q;
  assign busy_o      = busy_q;
  assign out_valid_o = valid_q;
  assign out_last_o  = last_q;
  assign out_data_o  = data_q;
  assign out_tag_o   = tag_q;
  assign cycle_o     = cycle_w;

endmodule

// File: tb/tb_debug_dump.sv
// tb/tb_debug_dump.sv - self-checking bench for debug_dump and sat_counter
`timescale 1ns/1ps
module tb_debug_dump;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        trigger_i;
  logic [4:0]  reg_addr_o;
  logic [31:0] reg_data_i;
  logic [2:0]  mem_addr_o;
  logic [31:0] mem_data_i;
  logic        cpu_stall_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic [7:0]  out_tag_o;
  logic        out_last_o;
  logic        busy_o;
  logic [31:0] cycle_o;

  logic [31:0] regfile [32];
  logic [31:0] memw [8];

  logic        sc_rst, sc_en, sc_load;
  logic [31:0] sc_val, sc_count;

  always #5 clk_i = ~clk_i;

  assign reg_data_i = regfile[reg_addr_o];
  assign mem_data_i = memw[mem_addr_o];

  debug_dump dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .trigger_i   (trigger_i),
    .reg_addr_o  (reg_addr_o),
    .reg_data_i  (reg_data_i),
    .mem_addr_o  (mem_addr_o),
    .mem_data_i  (mem_data_i),
    .cpu_stall_o (cpu_stall_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_tag_o   (out_tag_o),
    .out_last_o  (out_last_o),
    .busy_o      (busy_o),
    .cycle_o     (cycle_o)
  );

  sat_counter #(.WIDTH(32)) u_sc (
    .clk_i      (clk_i),
    .rst_i      (sc_rst),
    .en_i       (sc_en),
    .load_i     (sc_load),
    .load_val_i (sc_val),
    .count_o    (sc_count)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a dump is a list of 41 beats; the CPU is frozen from the trigger
  // edge until one edge after the 41st beat is accepted.
  logic [31:0] m_count;
  bit          m_stall, m_done, m_seen_valid;
  int          m_beats, m_lasts, m_since, last_budget;
  logic [7:0]  exp_tag [41];
  logic [31:0] exp_data [41];
  logic        exp_last [41];
  logic [7:0]  got_tag [41];
  logic [31:0] got_data [41];
  logic        got_last [41];

  typedef struct {
    int          beat;
    logic [7:0]  tag;
    logic [31:0] data;
    logic        last;
  } spot_t;

  typedef struct {
    int mode;        // 0 ready always, 1 ready toggling, 2 ready random
    int retrig;      // beat index during which trigger is pulsed again, -1 none
    int rst_beat;    // beat index at which reset hits, -1 none
    int pre;         // idle cycles with random start_i before the trigger
    int exp_budget;  // expected edges from trigger to stall release, -1 unchecked
  } scen_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic void build_expected(input logic [31:0] hdr);
    exp_tag[0] = 8'h00; exp_data[0] = hdr; exp_last[0] = 1'b0;
    for (int i = 0; i < 32; i++) begin
      exp_tag[1+i] = 8'h40 + 8'(i); exp_data[1+i] = regfile[i]; exp_last[1+i] = 1'b0;
    end
    for (int j = 0; j < 8; j++) begin
      exp_tag[33+j] = 8'h80 + 8'(j); exp_data[33+j] = memw[j]; exp_last[33+j] = (j == 7);
    end
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_stall"}, 32'(cpu_stall_o), 32'd0);
    check({tag, "_valid"}, 32'(out_valid_o), 32'd0);
    check({tag, "_last"}, 32'(out_last_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_reg_addr"}, 32'(reg_addr_o), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr_o), 32'd0);
    check({tag, "_data"}, out_data_o, 32'd0);
    check({tag, "_tag"}, 32'(out_tag_o), 32'd0);
    check({tag, "_cycle"}, cycle_o, 32'd0);
  endtask

  task automatic model_reset();
    m_count = 0; m_stall = 0; m_done = 0; m_beats = 0; m_lasts = 0; m_since = 0;
    m_seen_valid = 0;
  endtask

  task automatic set_ready(input int mode);
    case (mode)
      0:       out_ready_i = 1'b1;
      1:       out_ready_i = ~out_ready_i;
      default: out_ready_i = 1'($urandom_range(0, 1));
    endcase
  endtask

  // One clock edge: score the beat offered now, advance the model, check after the edge.
  task automatic step();
    bit          acc, hold;
    logic [31:0] h_data;
    logic [7:0]  h_tag;
    logic        h_last;
    acc    = out_valid_o && out_ready_i;
    hold   = out_valid_o && !out_ready_i;
    h_data = out_data_o; h_tag = out_tag_o; h_last = out_last_o;
    if (acc) begin
      if (m_beats < 41) begin
        got_tag[m_beats] = out_tag_o; got_data[m_beats] = out_data_o; got_last[m_beats] = out_last_o;
        check("beat_tag", 32'(out_tag_o), 32'(exp_tag[m_beats]));
        check("beat_data", out_data_o, exp_data[m_beats]);
        check("beat_last", 32'(out_last_o), 32'(exp_last[m_beats]));
      end else begin
        check("beat_overrun", 32'(m_beats), 32'd40);
      end
      if (out_last_o) m_lasts++;
      m_beats++;
    end
    if (start_i && !m_stall && m_count != 32'hFFFF_FFFF) m_count++;
    if (m_stall) m_since++;
    if (m_done) begin
      m_stall = 0; m_done = 0;
    end else if (m_stall && acc && m_beats == 41) begin
      m_done = 1;
    end else if (!m_stall && trigger_i) begin
      m_stall = 1; m_beats = 0; m_lasts = 0; m_since = 0; m_seen_valid = 0;
      build_expected(m_count);
    end
    @(posedge clk_i); #1;
    check("cycle", cycle_o, m_count);
    check("stall", 32'(cpu_stall_o), 32'(m_stall));
    check("busy", 32'(busy_o), 32'(m_stall));
    if (!m_stall) check("valid_idle", 32'(out_valid_o), 32'd0);
    if (hold) begin
      check("hold_valid", 32'(out_valid_o), 32'd1);
      check("hold_data", out_data_o, h_data);
      check("hold_tag", 32'(out_tag_o), 32'(h_tag));
      check("hold_last", 32'(out_last_o), 32'(h_last));
    end
    if (m_stall && out_valid_o && !m_seen_valid) begin
      m_seen_valid = 1;
      check("first_valid_latency", 32'(m_since), 32'd2);
    end
  endtask

  task automatic reset_mid();
    rst_i = 1'b1;
    #1;
    check_outputs_zero("mid_rst");
    check("abort_no_last", 32'(m_lasts), 32'd0);
    model_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic run_dump(input int mode, input int retrig, input int rst_beat);
    int budget;
    bit aborted;
    budget = 0; aborted = 0;
    trigger_i = 1'b1; set_ready(mode); step(); trigger_i = 1'b0;
    while (m_stall && budget < 400 && !aborted) begin
      if (rst_beat >= 0 && m_beats == rst_beat && out_valid_o) begin
        reset_mid(); aborted = 1;
      end else begin
        set_ready(mode);
        trigger_i = (m_beats == retrig) && out_valid_o;
        step();
        trigger_i = 1'b0;
        budget++;
      end
    end
    last_budget = budget;
    if (!aborted) begin
      if (m_stall) begin
        vectors++; miscompares++;
        $display("FAIL dump_timeout: got %0d beats after %0d cycles, want 41", m_beats, budget);
      end
      check("beat_count", 32'(m_beats), 32'd41);
      check("last_count", 32'(m_lasts), 32'd1);
    end
  endtask

  spot_t spot [5];
  scen_t scen [5];

  initial begin
    spot[0] = '{0,  8'h00, 32'd10,        1'b0};
    spot[1] = '{9,  8'h48, 32'd5,         1'b0};
    spot[2] = '{10, 8'h49, 32'd8,         1'b0};
    spot[3] = '{33, 8'h80, 32'd5,         1'b0};
    spot[4] = '{40, 8'h87, 32'h7777_0007, 1'b1};
    scen[0] = '{1, -1, -1, 3, 85};
    scen[1] = '{0,  6, -1, 2, 44};
    scen[2] = '{2, -1, -1, 5, -1};
    scen[3] = '{0, -1, 36, 4, -1};
    scen[4] = '{2, -1, -1, 6, -1};

    rst_i = 1'b1; start_i = 1'b0; trigger_i = 1'b0; out_ready_i = 1'b0;
    sc_rst = 1'b1; sc_en = 1'b0; sc_load = 1'b0; sc_val = '0;
    for (int i = 0; i < 32; i++) regfile[i] = $urandom;
    for (int j = 0; j < 8; j++) memw[j] = $urandom;
    model_reset();
    #1;
    check_outputs_zero("reset");
    @(posedge clk_i); #1;
    rst_i = 1'b0; sc_rst = 1'b0;

    // Saturating counter preloaded near the top.
    sc_load = 1'b1; sc_val = 32'hFFFF_FFFE;
    @(posedge clk_i); #1;
    sc_load = 1'b0;
    check("sat_preload", sc_count, 32'hFFFF_FFFE);
    sc_en = 1'b1;
    @(posedge clk_i); #1;
    check("sat_step1", sc_count, 32'hFFFF_FFFF);
    repeat (2) @(posedge clk_i);
    #1;
    check("sat_hold", sc_count, 32'hFFFF_FFFF);
    sc_en = 1'b0;

    // Free running, no trigger.
    start_i = 1'b1;
    repeat (10) step();
    check("run10_cycle", cycle_o, 32'd10);
    check("run10_stall", 32'(cpu_stall_o), 32'd0);
    check("run10_valid", 32'(out_valid_o), 32'd0);

    // Known-content dump triggered on the 10th running edge.
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_reset();
    regfile[8] = 32'd5; regfile[9] = 32'd8; memw[0] = 32'd5; memw[7] = 32'h7777_0007;
    repeat (9) step();
    run_dump(0, -1, -1);
    check("known_dump_cycles", 32'(last_budget), 32'd44);
    check("known_cycle_frozen", cycle_o, 32'd10);
    for (int k = 0; k < 5; k++) begin
      check("spot_tag", 32'(got_tag[spot[k].beat]), 32'(spot[k].tag));
      check("spot_data", got_data[spot[k].beat], spot[k].data);
      check("spot_last", 32'(got_last[spot[k].beat]), 32'(spot[k].last));
    end
    repeat (3) step();

    // Randomised scenarios.
    for (int s = 0; s < 5; s++) begin
      for (int i = 0; i < 32; i++) regfile[i] = $urandom;
      for (int j = 0; j < 8; j++) memw[j] = $urandom;
      for (int k = 0; k < scen[s].pre; k++) begin
        start_i = 1'($urandom_range(0, 1));
        step();
      end
      start_i = 1'b1;
      out_ready_i = 1'b0;
      run_dump(scen[s].mode, scen[s].retrig, scen[s].rst_beat);
      if (scen[s].exp_budget >= 0) check("dump_cycles", 32'(last_budget), 32'(scen[s].exp_budget));
      repeat (3) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/debug_dump.md
DEBUG_DUMP -- requirements
Module: debug_dump

Interface
REQ-001 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_i  in  1  reset, asynchronous, active-high.
REQ-003 start_i  in  1  CPU running qualifier; cycle counter advances only while high.
REQ-004 trigger_i  in  1  dump request, sampled each rising edge.
REQ-005 reg_addr_o  out  5  register-file read index; reg_data_i  in  32  combinational read data, same cycle.
REQ-006 mem_addr_o  out  3  data-memory word index (byte address = index*4); mem_data_i  in  32  combinational little-endian word, same cycle.
REQ-007 cpu_stall_o  out  1  freezes PC, pipeline registers and memory/register writes while high.
REQ-008 out_valid_o  out  1 / out_ready_i  in  1  stream handshake; beat transfers on a clock edge with both high.
REQ-009 out_data_o  out  32 / out_tag_o  out  8 {kind[7:6], index[5:0]}; kind 00 header, 01 register, 10 memory.
REQ-010 out_last_o  out  1  high on the final beat of a dump.
REQ-011 busy_o  out  1  high in any state other than IDLE; cycle_o  out  32  current cycle count.

Function
REQ-012 Cycle counter increments by 1 per edge when start_i=1 and cpu_stall_o=0; saturates at 0xFFFFFFFF, no wrap.
REQ-013 FSM states: IDLE, FREEZE, HDR, REG, MEM, DONE.
REQ-014 IDLE: trigger_i=1 -> FREEZE with cpu_stall_o registered high from the next cycle; trigger_i while not IDLE is ignored, not queued.
REQ-015 FREEZE lasts exactly 1 cycle, then HDR; first out_valid_o rises 2 cycles after the trigger edge.
REQ-016 HDR beat: data = cycle count frozen at FREEZE entry, tag 0x00.
REQ-017 REG: 32 beats, index 0..31, data = reg_data_i at reg_addr_o=index, tag {01,index}.
REQ-018 MEM: 8 beats, index 0..7, data = mem_data_i at mem_addr_o=index, tag {10,index}; out_last_o=1 on index 7 only.
REQ-019 Payload is registered: the next beat's data/tag load on the same edge that completes the current handshake, so a back-to-back ready stream moves 1 beat per cycle (41 beats in 41 cycles).
REQ-020 While out_valid_o=1 and out_ready_i=0, out_data_o, out_tag_o and out_last_o hold stable; valid never drops before the transfer completes.
REQ-021 Last beat accepted -> DONE for 1 cycle (valid low, stall still high) -> IDLE with stall low.
REQ-022 Register index 0 is read like any other register; no special-casing.
REQ-023 Read addresses are driven from the index register one cycle ahead of the payload load, so the read ports never observe an index change while their data is being sampled.

Reset
REQ-024 rst_i high immediately forces: state IDLE, counter 0, every output 0 (cpu_stall_o, out_valid_o, out_last_o, busy_o, reg_addr_o, mem_addr_o, out_data_o, out_tag_o, cycle_o).
REQ-025 Reset mid-dump aborts the dump without emitting a last beat; the first trigger after release starts a fresh dump at HDR.

Structure
REQ-026 Shared package dump_pkg holds NREG=32, NMEM=8, tag kind constants, and the FSM state enum.
REQ-027 The saturating cycle counter is one sub-module, sat_counter (enable, saturate, async clear).

Verification
REQ-028 Reset, start_i=1 for 10 cycles, no trigger -> cycle_o=10, cpu_stall_o=0, out_valid_o=0.
REQ-029 Registers r8=5, r9=8, memory word 0=5; trigger at cycle 10, out_ready_i=1 -> 41 consecutive beats: header 10, tag 0x48 data 5, tag 0x49 data 8, tag 0x80 data 5, last beat tag 0x87 with out_last_o=1; stall clears 1 cycle later; cycle_o stays 10 throughout.
REQ-030 out_ready_i toggled 1/0 every cycle -> identical 41-beat sequence in 82 cycles; data stable while ready is low.
REQ-031 trigger_i pulsed again during REG beat 5 -> no effect; exactly one out_last_o.
REQ-032 rst_i asserted during MEM beat 3 -> all outputs 0 at once; a new trigger yields a full 41-beat dump starting with a header carrying the post-reset count.
REQ-033 Counter preloaded to 0xFFFFFFFE, 3 running cycles -> cycle_o=0xFFFFFFFF, holds.
